// File: rtl/spram_rr_ctrl_pkg.sv
// rtl/spram_rr_ctrl_pkg.sv - shared types for the single-port RAM round-robin controller
package spram_ctrl_pkg;

   typedef enum logic {INIT, RUN} state_t;
   typedef enum logic {OWN_A, OWN_B} owner_t;

   localparam int DEF_ADDR_WIDTH = 8;
   localparam int DEPTH          = 2 ** DEF_ADDR_WIDTH;

   function automatic int depth_of(input int aw);
      return 1 << aw;
   endfunction

endpackage

// File: rtl/spram_rr_ctrl_if.sv
// rtl/spram_rr_ctrl_if.sv - requester A/B command and read-return bundle
interface spram_rr_ctrl_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 18
);
   logic                  a_req;
   logic                  a_we;
   logic [ADDR_WIDTH-1:0] a_addr;
   logic [DATA_WIDTH-1:0] a_wdata;
   logic                  a_gnt;
   logic                  a_rvalid;
   logic                  b_req;
   logic                  b_we;
   logic [ADDR_WIDTH-1:0] b_addr;
   logic [DATA_WIDTH-1:0] b_wdata;
   logic                  b_gnt;
   logic                  b_rvalid;
   logic [DATA_WIDTH-1:0] rdata;

   modport master (
      output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata,
      input  a_gnt, a_rvalid, b_gnt, b_rvalid, rdata
   );

   modport slave (
      input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata,
      output a_gnt, a_rvalid, b_gnt, b_rvalid, rdata
   );
endinterface

// File: rtl/spram_rr_ctrl_rr_arb2.sv
// rtl/spram_rr_ctrl_rr_arb2.sv - two-way round-robin arbiter with combinational grant
module rr_arb2
   import spram_ctrl_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_en,
   input  logic [1:0] i_req,
   output logic [1:0] o_gnt
);

   owner_t     r_last;
   logic [1:0] w_gnt;

   always_comb begin
      w_gnt = 2'b00;
      if (i_en) begin
         case (i_req)
            2'b01:   w_gnt = 2'b01;
            2'b10:   w_gnt = 2'b10;
            2'b11:   w_gnt = (r_last == OWN_B) ? 2'b01 : 2'b10;
            default: w_gnt = 2'b00;
         endcase
      end
   end

   // Reset to "B last" so A wins the first tie.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_last <= OWN_B;
      end else if (|w_gnt) begin
         r_last <= w_gnt[1] ? OWN_B : OWN_A;
      end
   end

   assign o_gnt = w_gnt;

endmodule

// File: rtl/spram_rr_ctrl.sv
// rtl/spram_rr_ctrl.sv - clears a single-port RAM after reset, then shares it between A and B
module spram_rr_ctrl
   import spram_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = 18,
   parameter int OUT_REG    = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   spram_rr_ctrl_if.slave        s_if,
   output logic                  o_ram_en,
   output logic                  o_ram_we,
   output logic [ADDR_WIDTH-1:0] o_ram_addr,
   output logic [DATA_WIDTH-1:0] o_ram_wdata,
   input  logic [DATA_WIDTH-1:0] i_ram_rdata,
   output logic                  o_ram_oreg_en,
   output logic                  o_busy
);

   localparam int NUM_WORDS = depth_of(ADDR_WIDTH);
   localparam int TAG_D     = 2 + OUT_REG;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_cnt;
   logic                  r_busy;
   logic                  r_ram_en;
   logic                  r_ram_we;
   logic [ADDR_WIDTH-1:0] r_ram_addr;
   logic [DATA_WIDTH-1:0] r_ram_wdata;
   logic [TAG_D-1:0]      r_tag_v;
   owner_t                r_tag_own [TAG_D];

   logic [1:0]            w_gnt;
   logic                  w_sel_b;
   logic                  w_we;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [DATA_WIDTH-1:0] w_wdata;
   logic                  w_rd_issue;
   logic                  w_out_v;

   rr_arb2 u_arb (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_en  (r_state == RUN),
      .i_req ({s_if.b_req, s_if.a_req}),
      .o_gnt (w_gnt)
   );

   assign w_sel_b    = w_gnt[1];
   assign w_we       = w_sel_b ? s_if.b_we    : s_if.a_we;
   assign w_addr     = w_sel_b ? s_if.b_addr  : s_if.a_addr;
   assign w_wdata    = w_sel_b ? s_if.b_wdata : s_if.a_wdata;
   assign w_rd_issue = (|w_gnt) && !w_we;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= INIT;
         r_cnt       <= '0;
         r_busy      <= 1'b1;
         r_ram_en    <= 1'b0;
         r_ram_we    <= 1'b0;
         r_ram_addr  <= '0;
         r_ram_wdata <= '0;
         r_tag_v     <= '0;
         for (int i = 0; i < TAG_D; i++) r_tag_own[i] <= OWN_A;
      end else begin
         case (r_state)
            INIT: begin
               r_ram_en    <= 1'b1;
               r_ram_we    <= 1'b1;
               r_ram_addr  <= r_cnt;
               r_ram_wdata <= '0;
               r_cnt       <= r_cnt + 1'b1;
               if (r_cnt == ADDR_WIDTH'(NUM_WORDS - 1)) begin
                  r_state <= RUN;
                  r_busy  <= 1'b0;
               end
            end
            RUN: begin
               r_ram_en <= |w_gnt;
               r_ram_we <= (|w_gnt) && w_we;
               if (|w_gnt) begin
                  r_ram_addr  <= w_addr;
                  r_ram_wdata <= w_wdata;
               end
            end
            default: r_state <= INIT;
         endcase
         // Stage k holds the read granted k+1 cycles ago; the last stage lines up with RAM data.
         r_tag_v      <= {r_tag_v[TAG_D-2:0], w_rd_issue};
         r_tag_own[0] <= w_sel_b ? OWN_B : OWN_A;
         for (int i = 1; i < TAG_D; i++) r_tag_own[i] <= r_tag_own[i-1];
      end
   end

   assign w_out_v       = r_tag_v[TAG_D-1];
   assign s_if.a_gnt    = w_gnt[0];
   assign s_if.b_gnt    = w_gnt[1];
   assign s_if.a_rvalid = w_out_v && (r_tag_own[TAG_D-1] == OWN_A);
   assign s_if.b_rvalid = w_out_v && (r_tag_own[TAG_D-1] == OWN_B);
   assign s_if.rdata    = w_out_v ? i_ram_rdata : '0;

   assign o_ram_en      = r_ram_en;
   assign o_ram_we      = r_ram_we;
   assign o_ram_addr    = r_ram_addr;
   assign o_ram_wdata   = r_ram_wdata;
   assign o_ram_oreg_en = (OUT_REG != 0) ? r_tag_v[1] : 1'b0;
   assign o_busy        = r_busy;

endmodule

// File: tb/tb_spram_rr_ctrl.sv
// tb/tb_spram_rr_ctrl.sv - scoreboard bench driving OUT_REG=0 and OUT_REG=1 instances in lockstep
module tb_spram_rr_ctrl;

   localparam int AW = 4;
   localparam int DW = 18;
   localparam int NW = 16;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } cmd_t;

   typedef struct {
      bit            own_b;
      logic [DW-1:0] data;
      int            due;
   } rd_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          a_req = 0, a_we = 0, b_req = 0, b_we = 0;
   logic [AW-1:0] a_addr = '0, b_addr = '0;
   logic [DW-1:0] a_wdata = '0, b_wdata = '0;
   logic          a_gnt0, b_gnt0;

   cmd_t qa[$];
   cmd_t qb[$];
   int   n_checks = 0;
   int   n_fail = 0;
   bit   rnd_gap = 0;
   bit   fa, fb;
   int   gap_a = 0, gap_b = 0;

   task automatic chk(input int inst, input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[or=%0d] t=%0t: got %h expected %h", nm, inst, $time, act, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int OR = g;

      spram_rr_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifc ();

      logic          ram_en, ram_we, oreg_en, busy;
      logic [AW-1:0] ram_addr;
      logic [DW-1:0] ram_wdata, ram_rdata, arr_q, oreg_q;
      logic [DW-1:0] mem [NW];

      assign ifc.a_req   = a_req;
      assign ifc.a_we    = a_we;
      assign ifc.a_addr  = a_addr;
      assign ifc.a_wdata = a_wdata;
      assign ifc.b_req   = b_req;
      assign ifc.b_we    = b_we;
      assign ifc.b_addr  = b_addr;
      assign ifc.b_wdata = b_wdata;

      spram_rr_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(OR)) u_dut (
         .i_clk         (clk),
         .i_rst         (rst),
         .s_if          (ifc),
         .o_ram_en      (ram_en),
         .o_ram_we      (ram_we),
         .o_ram_addr    (ram_addr),
         .o_ram_wdata   (ram_wdata),
         .i_ram_rdata   (ram_rdata),
         .o_ram_oreg_en (oreg_en),
         .o_busy        (busy)
      );

      // Single-port RAM with optional output register.
      always @(posedge clk) begin
         if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        arr_q <= mem[ram_addr];
         end
         if (oreg_en) oreg_q <= arr_q;
      end
      assign ram_rdata = (OR != 0) ? oreg_q : arr_q;

      rd_t           exp_q[$];
      int            cyc;
      bit            last_b;
      logic [DW-1:0] ref_mem [NW];
      bit            pend_v;
      cmd_t          pend_c;
      logic [AW-1:0] hold_addr;
      logic [DW-1:0] hold_wdata;
      bit            ga, gb, exp_oreg;
      cmd_t          c;
      rd_t           e;

      always @(negedge clk) begin
         if (rst) begin
            chk(g, "reset_state",
                {busy, ifc.a_gnt, ifc.b_gnt, ifc.a_rvalid, ifc.b_rvalid, ifc.rdata,
                 ram_en, ram_we, ram_addr, ram_wdata, oreg_en},
                {1'b1, 47'd0});
            cyc = 0; last_b = 1; pend_v = 0;
            hold_addr = AW'(NW - 1); hold_wdata = '0;
            exp_q.delete();
            foreach (ref_mem[i]) ref_mem[i] = '0;
         end else begin
            chk(g, "busy", busy, (cyc < NW));
            if (cyc >= 1 && cyc <= NW) begin
               chk(g, "init_cmd", {ram_en, ram_we, ram_addr, ram_wdata}, {2'b11, AW'(cyc - 1), 18'd0});
            end else if (cyc > NW) begin
               if (pend_v) chk(g, "ram_cmd", {ram_en, ram_we, ram_addr, ram_wdata},
                               {1'b1, pend_c.we, pend_c.addr, pend_c.data});
               else        chk(g, "ram_idle", {ram_en, ram_we, ram_addr, ram_wdata},
                               {2'b00, hold_addr, hold_wdata});
            end
            ga = 0; gb = 0;
            if (cyc >= NW) begin
               if (a_req && b_req) begin ga = last_b; gb = !last_b; end
               else begin ga = a_req; gb = b_req; end
            end
            chk(g, "gnt", {ifc.a_gnt, ifc.b_gnt}, {ga, gb});
            pend_v = 0;
            if (ga || gb) begin
               c = gb ? cmd_t'{b_we, b_addr, b_wdata} : cmd_t'{a_we, a_addr, a_wdata};
               last_b = gb; pend_v = 1; pend_c = c;
               hold_addr = c.addr; hold_wdata = c.data;
               if (c.we) ref_mem[c.addr] = c.data;
               else      exp_q.push_back('{gb, ref_mem[c.addr], cyc + 2 + OR});
            end
            exp_oreg = 0;
            if (OR != 0) foreach (exp_q[i]) if (exp_q[i].due == cyc + 1) exp_oreg = 1;
            chk(g, "oreg_en", oreg_en, exp_oreg);
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
               e = exp_q.pop_front();
               chk(g, "rvalid_data", {ifc.a_rvalid, ifc.b_rvalid, ifc.rdata}, {!e.own_b, e.own_b, e.data});
            end else begin
               chk(g, "no_rvalid", {ifc.a_rvalid, ifc.b_rvalid}, 2'b00);
            end
            cyc++;
         end
      end
   end

   assign a_gnt0 = g_dut[0].ifc.a_gnt;
   assign b_gnt0 = g_dut[0].ifc.b_gnt;

   // Requesters hold a command until granted, then present the next one.
   initial begin
      forever begin
         @(negedge clk);
         fa = a_req && a_gnt0;
         fb = b_req && b_gnt0;
         @(posedge clk);
         #1;
         if (fa && qa.size() > 0) begin void'(qa.pop_front()); if (rnd_gap) gap_a = $urandom_range(0, 2); end
         if (fb && qb.size() > 0) begin void'(qb.pop_front()); if (rnd_gap) gap_b = $urandom_range(0, 2); end
         if (gap_a > 0) begin gap_a--; a_req = 0; end
         else if (qa.size() > 0) begin a_req = 1; a_we = qa[0].we; a_addr = qa[0].addr; a_wdata = qa[0].data; end
         else a_req = 0;
         if (gap_b > 0) begin gap_b--; b_req = 0; end
         else if (qb.size() > 0) begin b_req = 1; b_we = qb[0].we; b_addr = qb[0].addr; b_wdata = qb[0].data; end
         else b_req = 0;
      end
   end

   task automatic wait_idle(input int maxc);
      int n = 0;
      while ((qa.size() > 0 || qb.size() > 0 || a_req || b_req ||
              g_dut[0].exp_q.size() > 0 || g_dut[1].exp_q.size() > 0) && n < maxc) begin
         @(posedge clk);
         n++;
      end
      n_checks++;
      if (n >= maxc) begin
         n_fail++;
         $display("FAIL drain_timeout: waited %0d cycles, limit %0d", n, maxc);
      end
      repeat (2) @(posedge clk);
      #2;
   endtask

   initial begin
      int n;
      rst = 1;
      repeat (2) @(posedge clk);
      #2 rst = 0;
      repeat (20) @(posedge clk);
      #2;

      qa.push_back({1'b1, 4'd5, 18'h3FFFF});
      qa.push_back({1'b0, 4'd5, 18'h0});
      wait_idle(60);

      qa.push_back({1'b1, 4'd1, 18'h11});
      qb.push_back({1'b1, 4'd2, 18'h22});
      wait_idle(60);
      for (int i = 0; i < 6; i++) begin
         qa.push_back({1'b0, 4'd1, 18'h0});
         qb.push_back({1'b0, 4'd2, 18'h0});
      end
      wait_idle(100);

      for (int i = 0; i < 6; i++) qb.push_back({1'b0, 4'($urandom_range(0, 15)), 18'h0});
      repeat (4) @(posedge clk);
      #2;
      for (int i = 0; i < 3; i++) qa.push_back({1'b0, 4'($urandom_range(0, 15)), 18'h0});
      wait_idle(100);

      rnd_gap = 1;
      for (int i = 0; i < 80; i++) begin
         qa.push_back({1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 18'($urandom)});
         qb.push_back({1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 18'($urandom)});
      end
      wait_idle(2000);
      rnd_gap = 0;

      for (int i = 0; i < 3; i++) qa.push_back({1'b0, 4'(i + 4), 18'h0});
      n = 0;
      while (!(a_req && a_gnt0) && n < 20) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (n >= 20) begin
         n_fail++;
         $display("FAIL first_grant_timeout: waited %0d cycles, limit 20", n);
      end
      @(posedge clk);
      #2 rst = 1;
      qa.delete();
      qb.delete();
      @(posedge clk);
      #2 rst = 0;

      qa.push_back({1'b0, 4'd3, 18'h0});
      wait_idle(100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
